// File: rtl/mux_sel_pipe.sv
// ---------------------------------------------------------------------------
// mux_sel_pipe
//   N-way, WIDTH-bit result selector with one registered output stage and
//   valid/ready handshakes on both sides.  Sits between the ALU functional
//   units and the writeback/result register.
//
//   Two select modes:
//     scan = 0 : direct mode, the input at index 'sel' is taken.
//     scan = 1 : round-robin mode, an internal pointer picks the input and
//                steps 0,1,..,NUM_IN-1,0,... once per accepted selection.
//   An index in NUM_IN..2**SEL_W-1 is accepted, not blocked: it produces
//   out_data = 0 with sel_err = 1.
//
//   Optional build macro: MUX_SEL_PIPE_FLAGS_EN
//     When defined, adds registered out_zero / out_neg flags describing the
//     value loaded into out_data.  When undefined the ports do not exist.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_bus     in   NUM_IN*WIDTH flattened inputs, input k at [k*WIDTH +: WIDTH]
//   sel        in   SEL_W input index (direct mode)
//   scan       in   0 = direct, 1 = round-robin
//   in_valid   in   upstream offers a selection
//   in_ready   out  block accepts a selection this cycle
//   out_data   out  WIDTH registered selected value
//   out_idx    out  SEL_W index that produced out_data
//   out_valid  out  out_data / out_idx / sel_err are valid
//   out_ready  in   downstream accepts out_data
//   sel_err    out  out_data came from an out-of-range index
//   out_zero   out  (MUX_SEL_PIPE_FLAGS_EN) out_data was loaded with zero
//   out_neg    out  (MUX_SEL_PIPE_FLAGS_EN) out_data MSB at load time
//
// Handshake: a transfer happens on a rising edge where valid && ready.
//   Upstream: capture = in_valid && in_ready, with in_ready = !out_valid ||
//   out_ready, so the output register may be refilled on the same edge it
//   drains.  Downstream: out_valid stays high and out_* stay stable until
//   out_ready is seen; once valid is raised it is never withdrawn without a
//   transfer except by rst.
// ---------------------------------------------------------------------------
module mux_sel_pipe #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 8,
   parameter int SEL_W  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    scan,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_idx,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sel_err
`ifdef MUX_SEL_PIPE_FLAGS_EN
   ,
   output logic                    out_zero,
   output logic                    out_neg
`endif
);

   // Last legal index, where the round-robin pointer wraps back to 0.
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);
   // NUM_IN with one extra bit so the range compare is valid even when
   // 2**SEL_W == NUM_IN.
   localparam logic [SEL_W:0]   NUM_IN_X = (SEL_W + 1)'(NUM_IN);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] eff;
   logic             eff_oor;
   logic             capture;
   logic [WIDTH-1:0] sel_data;
   logic [WIDTH-1:0] nxt_data;

   assign in_ready = !out_valid || out_ready;
   assign capture  = in_valid && in_ready;
   assign eff      = scan ? ptr : sel;
   assign eff_oor  = {1'b0, eff} >= NUM_IN_X;

   // Input slice selection; an index with no matching input leaves zero.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (eff == SEL_W'(k)) begin
            sel_data = in_bus[k*WIDTH +: WIDTH];
         end
      end
   end

   assign nxt_data = eff_oor ? '0 : sel_data;

   // Output stage and round-robin pointer.  rst wins over capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_idx   <= '0;
         out_valid <= 1'b0;
         sel_err   <= 1'b0;
         ptr       <= '0;
      end else begin
         if (capture) begin
            out_data  <= nxt_data;
            out_idx   <= eff;
            sel_err   <= eff_oor;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            // Drain without refill: payload holds, only valid drops.
            out_valid <= 1'b0;
         end

         if (capture && scan) begin
            ptr <= (ptr == LAST_IDX) ? '0 : ptr + SEL_W'(1);
         end
      end
   end

`ifdef MUX_SEL_PIPE_FLAGS_EN
   // Flags describe the value being loaded, so they are taken from
   // nxt_data rather than from the out_data register.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_zero <= 1'b0;
         out_neg  <= 1'b0;
      end else if (capture) begin
         out_zero <= (nxt_data == '0);
         out_neg  <= nxt_data[WIDTH-1];
      end
   end
`endif

endmodule

// File: tb/tb_mux_sel_pipe.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_pipe
//   Self-checking bench for mux_sel_pipe.  Main instance: 8 inputs x 32 bits.
//   Second instance: 5 inputs, 3-bit select, for out-of-range indices and
//   non-power-of-two pointer wrap.
// ---------------------------------------------------------------------------
module tb_mux_sel_pipe;

   localparam int W  = 32;
   localparam int NI = 8;
   localparam int SW = 3;
   localparam int N5 = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [NI*W-1:0] in_bus = '0;
   logic [SW-1:0]   sel = '0;
   logic            scan = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W-1:0]    out_data;
   logic [SW-1:0]   out_idx;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic            sel_err;

   logic [N5*W-1:0] in_bus5;
   logic [SW-1:0]   sel5 = '0;
   logic            scan5 = 1'b0;
   logic            in_valid5 = 1'b0;
   logic            in_ready5;
   logic [W-1:0]    out_data5;
   logic [SW-1:0]   out_idx5;
   logic            out_valid5;
   logic            out_ready5 = 1'b1;
   logic            sel_err5;
`ifdef MUX_SEL_PIPE_FLAGS_EN
   logic            out_zero, out_neg, out_zero5, out_neg5;
`endif

   assign in_bus5 = in_bus[N5*W-1:0];

   mux_sel_pipe #(.WIDTH(W), .NUM_IN(NI), .SEL_W(SW)) u_dut (
      .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .scan(scan),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
      .sel_err(sel_err)
`ifdef MUX_SEL_PIPE_FLAGS_EN
      , .out_zero(out_zero), .out_neg(out_neg)
`endif
   );

   mux_sel_pipe #(.WIDTH(W), .NUM_IN(N5), .SEL_W(SW)) u_dut5 (
      .clk(clk), .rst(rst), .in_bus(in_bus5), .sel(sel5), .scan(scan5),
      .in_valid(in_valid5), .in_ready(in_ready5), .out_data(out_data5),
      .out_idx(out_idx5), .out_valid(out_valid5), .out_ready(out_ready5),
      .sel_err(sel_err5)
`ifdef MUX_SEL_PIPE_FLAGS_EN
      , .out_zero(out_zero5), .out_neg(out_neg5)
`endif
   );

   // ---------------- scoreboard / reference model ----------------
   logic [W-1:0] words[NI];     // value presented on input k
   logic [W-1:0] exp_q[$];      // results accepted but not yet drained
   logic [W-1:0] m_data;        // value last loaded into out_data
   int           m_idx;
   bit           m_err;
   bit           m_zero, m_neg;
   int           m_ptr;
   int           n_tests = 0;
   int           n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic pack_bus();
      for (int k = 0; k < NI; k++) in_bus[k*W +: W] = words[k];
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_data = '0; m_idx = 0; m_err = 1'b0; m_ptr = 0;
      m_zero = 1'b0; m_neg = 1'b0;
   endtask

   // Reset with upstream offering data, to show rst beats capture.
   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b1; scan = 1'b1; out_ready = 1'b0; in_valid5 = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; in_valid5 = 1'b0; out_ready = 1'b1;
      model_reset();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_idx", 32'(out_idx), 32'd0);
      check("rst_sel_err", 32'(sel_err), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid5", 32'(out_valid5), 32'd0);
`ifdef MUX_SEL_PIPE_FLAGS_EN
      check("rst_out_zero", 32'(out_zero), 32'd0);
      check("rst_out_neg", 32'(out_neg), 32'd0);
`endif
   endtask

   // One cycle on the main instance, checked against the model.
   task automatic step(input bit v, input bit sc, input int s, input bit ordy);
      bit           pend, exp_ready, cap;
      int           eff;
      logic [W-1:0] d;
      in_valid = v; scan = sc; sel = SW'(s); out_ready = ordy;
      pack_bus();
      #1;
      pend      = exp_q.size() != 0;
      exp_ready = !pend || ordy;
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      cap = v && exp_ready;
      eff = sc ? m_ptr : s;
      if (pend && ordy) void'(exp_q.pop_front());
      if (cap) begin
         d = (eff < NI) ? words[eff] : '0;
         exp_q.push_back(d);
         m_data = d; m_idx = eff; m_err = (eff >= NI);
         m_zero = (d == 0); m_neg = d[W-1];
         if (sc) m_ptr = (m_ptr + 1) % NI;
      end
      @(posedge clk); #1;
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : m_data);
      check("out_idx", 32'(out_idx), 32'(m_idx));
      check("sel_err", 32'(sel_err), 32'(m_err));
`ifdef MUX_SEL_PIPE_FLAGS_EN
      check("out_zero", 32'(out_zero), 32'(m_zero));
      check("out_neg", 32'(out_neg), 32'(m_neg));
`endif
   endtask

   // One cycle on the 5-input instance (out_ready5 held 1) with
   // hand-derived expectations.
   logic [W-1:0] last5;
   task automatic step5(input bit v, input bit sc, input int s, input int e_idx, input bit e_err);
      logic [W-1:0] e_data;
      in_valid5 = v; scan5 = sc; sel5 = SW'(s);
      pack_bus();
      #1;
      check("in_ready5", 32'(in_ready5), 32'd1);
      @(posedge clk); #1;
      check("out_valid5", 32'(out_valid5), 32'(v));
      if (v) begin
         e_data = e_err ? '0 : words[e_idx];
         last5  = e_data;
         check("out_idx5", 32'(out_idx5), 32'(e_idx));
         check("sel_err5", 32'(sel_err5), 32'(e_err));
      end
      check("out_data5", out_data5, last5);
      in_valid5 = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          v;
      bit          sc;
      logic [2:0]  s;
      bit          ordy;
      bit          exp_ready;
      bit          exp_valid;
      logic [2:0]  exp_idx;
      logic [31:0] exp_data;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs[NV];

   localparam logic [31:0] BASE = 32'h1000_0000;

   // ---------------- main sequence ----------------
   initial begin
      // Direct mode sel = 0..7, then scan: seven captures, idle, five more.
      for (int k = 0; k < 8; k++)
         vecs[k] = '{1'b1, 1'b0, 3'(k), 1'b1, 1'b1, 1'b1, 3'(k), BASE + 32'(k)};
      // sel deliberately disagrees with the expected pointer in scan mode.
      for (int j = 0; j < 7; j++)
         vecs[8+j] = '{1'b1, 1'b1, 3'(7-j), 1'b1, 1'b1, 1'b1, 3'(j), BASE + 32'(j)};
      vecs[15] = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 3'd6, BASE + 32'd6};
      for (int j = 0; j < 5; j++)
         vecs[16+j] = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 3'((7+j)%8), BASE + 32'((7+j)%8)};

      for (int k = 0; k < NI; k++) words[k] = BASE + 32'(k);
      pack_bus();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      for (int i = 0; i < NV; i++) begin
         in_valid = vecs[i].v; scan = vecs[i].sc; sel = vecs[i].s; out_ready = vecs[i].ordy;
         #1;
         check("tbl_in_ready", 32'(in_ready), 32'(vecs[i].exp_ready));
         @(posedge clk); #1;
         check("tbl_out_valid", 32'(out_valid), 32'(vecs[i].exp_valid));
         check("tbl_out_idx", 32'(out_idx), 32'(vecs[i].exp_idx));
         check("tbl_out_data", out_data, vecs[i].exp_data);
         check("tbl_sel_err", 32'(sel_err), 32'd0);
      end

      // Back-pressure: hold sel = 3 result while inputs churn, then
      // drain and refill on the same edge.
      do_reset();
      step(1, 0, 3, 1);
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < NI; k++) words[k] = $urandom;
         step(1, 0, $urandom_range(0, 7), 0);
         check("bp_hold_data", out_data, BASE + 32'd3);
      end
      step(1, 0, 5, 1);
      check("bp_refill_data", out_data, words[5]);

      // Reset mid-stall clears the pending result and the pointer.
      step(1, 1, 0, 1);
      step(1, 1, 0, 1);
      step(1, 0, 4, 0);
      step(0, 0, 0, 0);
      do_reset();
      step(1, 1, 6, 1);
      check("ptr_after_rst", 32'(out_idx), 32'd0);

      // Sign / zero values (flags checked by the model when built in).
      words[1] = 32'h8000_0000;
      words[2] = 32'h0;
      step(1, 0, 1, 1);
      step(1, 0, 2, 1);
      step(1, 0, 1, 1);

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) words[$urandom_range(0, NI-1)] = $urandom;
         if ($urandom_range(0, 7) == 0) words[$urandom_range(0, NI-1)] = '0;
         if ($urandom_range(0, 149) == 0) do_reset();
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 7), $urandom_range(0, 2) != 0);
      end

      // 5-input instance: out-of-range indices and pointer wrap at 4.
      for (int k = 0; k < NI; k++) words[k] = $urandom | 32'h1;
      do_reset();
      last5 = '0;
      step5(1, 0, 6, 6, 1);
      step5(1, 0, 2, 2, 0);
      step5(1, 0, 7, 7, 1);
      step5(1, 0, 5, 5, 1);
      step5(1, 0, 4, 4, 0);
      for (int j = 0; j < 7; j++) step5(1, 1, 6, j % N5, 0);
      step5(0, 1, 0, 0, 0);
      step5(1, 1, 0, 2, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
- Parametrised N-way, WIDTH-bit result selector with one registered output stage and valid/ready handshakes on both sides.
- Generalises the 8:1 32-bit combinational selector used at the ALU result stage.
- Adds a round-robin scan mode, out-of-range select detection, and back-pressure.
- Sits between the ALU functional units and the writeback/result register.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 8, number of inputs; legal range 2..16.
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_bus  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  input index; used in direct mode.
- scan  input  1  0 = direct mode (use sel); 1 = round-robin mode (use internal pointer).
- in_valid  input  1  upstream offers a selection this cycle.
- in_ready  output  1  block can accept a selection this cycle.
- out_data  output  WIDTH  registered selected value.
- out_idx  output  SEL_W  index that produced out_data.
- out_valid  output  1  out_data/out_idx valid.
- out_ready  input  1  downstream accepts out_data.
- sel_err  output  1  registered; current out_data came from an out-of-range index.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on rising clk.
- Reset values:
  - out_data = 0, out_idx = 0, out_valid = 0, sel_err = 0.
  - Round-robin pointer ptr = 0.
  - in_ready reads 1 from the first cycle after reset.
- in_ready is combinational: in_ready = !out_valid || out_ready. This gives full throughput with no bubble when downstream is always ready.
- Capture occurs when in_valid && in_ready. On capture:
  - Effective index eff = scan ? ptr : sel.
  - If eff < NUM_IN: out_data <= in_bus slice eff, sel_err <= 0.
  - If eff >= NUM_IN: out_data <= 0, sel_err <= 1.
  - out_idx <= eff, out_valid <= 1.
- Latency: exactly 1 cycle from capture to out_valid.
- If out_valid && out_ready and there is no capture: out_valid <= 0. out_data, out_idx and sel_err hold their last values.
- Simultaneous drain and capture: out_valid stays 1 and the new data replaces the old in the same edge; no data is lost.
- Stall (out_valid && !out_ready): in_ready = 0 and all registers hold. Input data may change freely while stalled; only the value present at capture matters.
- Round-robin pointer:
  - Advances only on capture while scan = 1.
  - Steps ptr <= ptr + 1, wrapping from NUM_IN-1 to 0, so ptr never reaches an out-of-range value.
  - Holds when scan = 0.
  - Toggling scan does not reset ptr.
- rst asserted mid-transfer (out_valid = 1, stalled): the pending result is discarded and every register returns to its reset value on that edge. rst takes priority over capture.
- sel values in NUM_IN..2**SEL_W-1 are legal inputs: they are flagged via sel_err, not blocked.
- No combinational path from in_bus or sel to any output.

Optional Feature:
- Macro: MUX_SEL_PIPE_FLAGS_EN.
- When defined, add two registered outputs, both updated only on capture and reset to 0:
  - out_zero  output  1: next out_data == 0.
  - out_neg  output  1: next out_data[WIDTH-1].
- When not defined, neither port exists and there is no flag logic. All other behaviour is identical in both builds.

Test Plan:
- Reset then direct mode, out_ready = 1. Set in_bus[k] = 32'h1000_0000 + k, drive sel = 0..7 on consecutive cycles with in_valid = 1 -> out_data = 0x1000_0000..0x1000_0007 one cycle later each, out_valid held 1, sel_err = 0, in_ready always 1.
- NUM_IN = 5, SEL_W = 3, sel = 6 -> out_data = 0, out_idx = 6, sel_err = 1. Next capture with sel = 2 -> in_bus slice 2, sel_err = 0.
- Scan mode, NUM_IN = 8, seven captures, then one idle cycle (in_valid = 0), then five more captures -> out_idx sequence 0..7 then 0..3. ptr does not advance on the idle cycle.
- Back-pressure: capture sel = 3, hold out_ready = 0 for 4 cycles while changing in_bus and sel -> in_ready = 0, out_data = original slice 3 throughout. Raise out_ready with in_valid = 1, sel = 5 -> same edge drains the old value and loads slice 5, out_valid stays 1.
- Reset mid-stall: out_valid = 1, out_ready = 0, assert rst for 1 cycle -> next cycle out_valid = 0, out_data = 0, ptr = 0, in_ready = 1.
- With MUX_SEL_PIPE_FLAGS_EN defined: select 32'h8000_0000 -> out_neg = 1, out_zero = 0. Select 32'h0 -> out_zero = 1, out_neg = 0.
